// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR digital loop filter: vote decode,
// gain field widths and a clamping adder used for the integrator and output word.
package cdr_pkg;

  localparam int KP_W = 3;
  localparam int KI_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    DN   = 2'b01,
    UP   = 2'b10,
    BOTH = 2'b11
  } vote_e;

  // Adds in 64-bit signed space, then clamps to the unsigned range [0, 2^w-1].
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    sum = a + b;
    hi  = (64'sd1 <<< w) - 64'sd1;
    if (sum < 64'sd0) return 64'sd0;
    else if (sum > hi) return hi;
    return sum;
  endfunction

endpackage

// File: rtl/cdr_dlf_win.sv
// Vote decoder and decimation window: accumulates signed votes over DECIM
// counted votes and strobes done (with the completed sum s) on the last one.
module cdr_dlf_win
  import cdr_pkg::*;
#(
  parameter int DECIM = 8,
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1,
  localparam int SW = $clog2(DECIM) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 up,
  input  logic                 dn,
  output logic signed [SW-1:0] s,
  output logic                 done
);

  localparam logic signed [SW-1:0] ONE = 1;

  vote_e                vote;
  logic signed [SW-1:0] v;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  assign vote = vote_e'({up, dn});

  always_comb begin
    v = '0;
    unique case (vote)
      UP:      v = ONE;
      DN:      v = -ONE;
      default: v = '0;
    endcase
  end

  // s includes this cycle's vote so the filter can act on the final vote without a bubble
  assign s    = sum_q + v;
  assign done = en && (cnt_q == CW'(DECIM - 1));

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (clr) begin
      cnt_d = '0;
      sum_d = '0;
    end else if (en) begin
      if (done) begin
        cnt_d = '0;
        sum_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sum_d = s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/cdr_dlf.sv
// CDR proportional-integral digital loop filter producing an offset-binary DCO word
// once per decimation window. Optional lock detector under CDR_DLF_LOCK_DET_EN.
module cdr_dlf
  import cdr_pkg::*;
#(
  parameter int CTRL_W   = 10,
  parameter int INT_W    = 20,
  parameter int DECIM    = 8,
  parameter int LOCK_THR = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pd_valid,
  input  logic              pd_up,
  input  logic              pd_dn,
  input  logic [KP_W-1:0]   kp,
  input  logic [KI_W-1:0]   ki,
  input  logic              load,
  input  logic [CTRL_W-1:0] init_word,
  input  logic              freeze,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              int_sat,
  output logic              lock
);

  localparam int SW = $clog2(DECIM) + 2;
  localparam int SH = INT_W - CTRL_W;
  localparam logic [INT_W-1:0]  INT_MAX  = '1;
  localparam logic [INT_W-1:0]  INT_MID  = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [CTRL_W-1:0] CTRL_MID = {1'b1, {(CTRL_W-1){1'b0}}};

  logic signed [SW-1:0] s;
  logic                 done;

  // load discards any vote in its cycle, freeze simply stops counting
  cdr_dlf_win #(.DECIM(DECIM)) u_win (
    .clk  (clk),
    .rst  (rst),
    .en   (pd_valid & ~freeze & ~load),
    .clr  (load),
    .up   (pd_up),
    .dn   (pd_dn),
    .s    (s),
    .done (done)
  );

  logic [INT_W-1:0]  integ_q, integ_d, integ_new, integ_ld;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_new;
  logic              vld_q, vld_d, sat_q, sat_d;

  assign integ_ld  = {init_word, {SH{1'b0}}};
  assign integ_new = INT_W'(sat_add(64'(integ_q), 64'(s) <<< ki, INT_W));
  assign ctrl_new  = CTRL_W'(sat_add(64'(integ_new[INT_W-1 -: CTRL_W]), 64'(s) <<< kp, CTRL_W));

  always_comb begin
    integ_d = integ_q;
    ctrl_d  = ctrl_q;
    sat_d   = sat_q;
    vld_d   = 1'b0;
    if (load) begin
      integ_d = integ_ld;
      ctrl_d  = init_word;
      sat_d   = (integ_ld == '0) || (integ_ld == INT_MAX);
      vld_d   = 1'b1;
    end else if (done) begin
      integ_d = integ_new;
      ctrl_d  = ctrl_new;
      sat_d   = (integ_new == '0) || (integ_new == INT_MAX);
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= INT_MID;
      ctrl_q  <= CTRL_MID;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      integ_q <= integ_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
    end
  end

  assign ctrl_out   = ctrl_q;
  assign ctrl_valid = vld_q;
  assign int_sat    = sat_q;

`ifdef CDR_DLF_LOCK_DET_EN
  localparam int QW = $clog2(LOCK_CNT + 1);

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          lock_q, lock_d;
  logic [SW-1:0] s_abs;
  logic          quiet;

  assign s_abs = s[SW-1] ? SW'(-s) : SW'(s);
  assign quiet = (int'(s_abs) <= LOCK_THR);

  always_comb begin
    qcnt_d = qcnt_q;
    lock_d = lock_q;
    if (load) begin
      qcnt_d = '0;
      lock_d = 1'b0;
    end else if (done) begin
      if (quiet) begin
        qcnt_d = (qcnt_q == QW'(LOCK_CNT)) ? qcnt_q : qcnt_q + 1'b1;
        lock_d = (qcnt_d == QW'(LOCK_CNT));
      end else begin
        qcnt_d = '0;
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      qcnt_q <= qcnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_dlf.sv
// Self-checking bench for cdr_dlf: directed scenarios plus randomized traffic
// compared every cycle against a window-level arithmetic model.
module tb_cdr_dlf;

  localparam int CTRL_W   = 10;
  localparam int INT_W    = 20;
  localparam int DECIM    = 8;
  localparam int LOCK_THR = 2;
  localparam int LOCK_CNT = 4;
  localparam longint IMAX = (longint'(1) << INT_W) - 1;
  localparam longint CMAX = (longint'(1) << CTRL_W) - 1;

  logic              clk = 1'b0;
  logic              rst, pd_valid, pd_up, pd_dn, load, freeze;
  logic [2:0]        kp;
  logic [3:0]        ki;
  logic [CTRL_W-1:0] init_word;
  logic [CTRL_W-1:0] ctrl_out;
  logic              ctrl_valid, int_sat, lock;

  always #5 clk = ~clk;

  cdr_dlf #(
    .CTRL_W(CTRL_W), .INT_W(INT_W), .DECIM(DECIM),
    .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst(rst), .pd_valid(pd_valid), .pd_up(pd_up), .pd_dn(pd_dn),
    .kp(kp), .ki(ki), .load(load), .init_word(init_word), .freeze(freeze),
    .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .int_sat(int_sat), .lock(lock)
  );

  int n_checks = 0;
  int n_fail   = 0;

  longint m_integ, m_ctrl;
  int     m_cnt, m_sum, m_q;
  bit     m_vld, m_sat, m_lock;
  int     c_kp, c_ki, c_iw;
  int     vld_seen;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampv(input longint x, input longint hi);
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic void model_step(input bit r, ld, frz, pv, up, dn);
    longint s;
    m_vld = 1'b0;
    if (r) begin
      m_integ = longint'(1) << (INT_W - 1);
      m_ctrl  = longint'(1) << (CTRL_W - 1);
      m_sat = 0; m_lock = 0; m_cnt = 0; m_sum = 0; m_q = 0;
    end else if (ld) begin
      m_integ = longint'(c_iw) * (longint'(1) << (INT_W - CTRL_W));
      m_ctrl  = c_iw;
      m_vld   = 1'b1;
      m_sat   = (m_integ == 0) || (m_integ == IMAX);
      m_cnt = 0; m_sum = 0; m_lock = 0; m_q = 0;
    end else if (!frz && pv) begin
      m_sum += (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
      m_cnt++;
      if (m_cnt == DECIM) begin
        s       = m_sum;
        m_integ = clampv(m_integ + s * (longint'(1) << c_ki), IMAX);
        m_ctrl  = clampv(m_integ / (longint'(1) << (INT_W - CTRL_W)) + s * (longint'(1) << c_kp), CMAX);
        m_vld   = 1'b1;
        m_sat   = (m_integ == 0) || (m_integ == IMAX);
`ifdef CDR_DLF_LOCK_DET_EN
        if (s <= LOCK_THR && s >= -LOCK_THR) begin
          if (m_q < LOCK_CNT) m_q++;
        end else begin
          m_q = 0;
        end
        m_lock = (m_q == LOCK_CNT);
`endif
        m_cnt = 0;
        m_sum = 0;
      end
    end
  endfunction

  task automatic step(input bit r, ld, frz, pv, up, dn);
    rst = r; load = ld; freeze = frz; pd_valid = pv; pd_up = up; pd_dn = dn;
    kp = c_kp[2:0]; ki = c_ki[3:0]; init_word = c_iw[CTRL_W-1:0];
    @(posedge clk);
    #1;
    model_step(r, ld, frz, pv, up, dn);
    check_eq("ctrl_out", ctrl_out, m_ctrl);
    check_eq("ctrl_valid", ctrl_valid, m_vld);
    check_eq("int_sat", int_sat, m_sat);
    check_eq("lock", lock, m_lock);
    if (ctrl_valid === 1'b1) vld_seen++;
  endtask

  task automatic vote(input bit up, dn);
    step(0, 0, 0, 1, up, dn);
  endtask

  initial begin
    int bias;
    c_kp = 0; c_ki = 0; c_iw = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("reset_ctrl", ctrl_out, 512);
    check_eq("reset_vld", ctrl_valid, 0);
    check_eq("reset_sat", int_sat, 0);
    check_eq("reset_lock", lock, 0);

    c_kp = 2; c_ki = 4;
    for (int i = 0; i < DECIM; i++) vote(1, 0);
    check_eq("up_window_ctrl", ctrl_out, 544);
    check_eq("up_window_vld", ctrl_valid, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("up_window_vld_drop", ctrl_valid, 0);

    step(1, 0, 0, 0, 0, 0);
    c_kp = 0; c_ki = 15;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < DECIM; i++) vote(0, 1);
      check_eq("dn_rail_ctrl", ctrl_out, (w == 0) ? 248 : 0);
      check_eq("dn_rail_sat", int_sat, (w == 0) ? 0 : 1);
    end

    step(1, 0, 0, 0, 0, 0);
    c_kp = 2; c_ki = 4;
    for (int i = 0; i < 5; i++) vote(1, 0);
    c_iw = 100;
    step(0, 1, 0, 1, 1, 0);
    check_eq("load_ctrl", ctrl_out, 100);
    check_eq("load_vld", ctrl_valid, 1);
    c_kp = 0; c_ki = 0;
    for (int i = 0; i < DECIM; i++) vote(1, 0);
    check_eq("post_load_ctrl", ctrl_out, 108);

    vld_seen = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 1, 0);
    check_eq("freeze_no_update", vld_seen, 0);
    check_eq("freeze_hold_ctrl", ctrl_out, 108);
    for (int i = 0; i < DECIM; i++) vote(1, 0);
    check_eq("unfreeze_one_update", vld_seen, 1);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 * DECIM; i++) vote(i % 2 == 0, i % 2 == 1);
`ifdef CDR_DLF_LOCK_DET_EN
    check_eq("lock_after_quiet", lock, 1);
`else
    check_eq("lock_after_quiet", lock, 0);
`endif
    for (int i = 0; i < DECIM; i++) vote(1, 0);
    check_eq("lock_drop", lock, 0);

    for (int i = 0; i < 3; i++) vote(1, 0);
    step(1, 0, 0, 0, 0, 0);
    vld_seen = 0;
    for (int i = 0; i < DECIM - 1; i++) vote(0, 1);
    check_eq("rst_partial_discard", vld_seen, 0);
    vote(0, 1);
    check_eq("rst_fresh_window", ctrl_valid, 1);

    bias = 2;
    for (int i = 0; i < 4000; i++) begin
      bit r, ld, frz, pv, up, dn;
      if (i % 200 == 0) bias = $urandom_range(0, 4);
      r   = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 63) == 0);
      frz = ($urandom_range(0, 7) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      up  = ($urandom_range(0, 4) < bias);
      dn  = ($urandom_range(0, 4) >= bias);
      if ($urandom_range(0, 7) == 0) begin
        up = 1'b1; dn = 1'b1;
      end
      c_kp = $urandom_range(0, 7);
      c_ki = $urandom_range(0, 15);
      c_iw = $urandom_range(0, 1023);
      if ($urandom_range(0, 15) == 0) c_iw = 0;
      step(r, ld, frz, pv, up, dn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
